// File: rtl/key_event_pkg.sv
// ============================================================================
// Module   : key_event_pkg
// Purpose  : Shared state encoding and counter sizing for key_event_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        GAP   = 3'd2,
        DOWN2 = 3'd3,
        LONG  = 3'd4
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                              input int unsigned gap_cycles);
        int unsigned max_cycles;
        max_cycles = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
// ============================================================================
// Module   : edge_detect
// Purpose  : Previous-level register with rise/fall strobes for a clean level.
// Revision : 1.0
// ============================================================================
`default_nettype none

module edge_detect (
    input  logic clk,
    input  logic key_in,
    output logic rise,
    output logic fall
);

    logic key_d;
    logic key_q;

    always_comb begin
        key_d = key_in;
    end

    // Loads unconditionally, so during reset key_q tracks key_in and a key
    // held across reset release produces no rise.
    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    assign rise = key_in & ~key_q;
    assign fall = ~key_in & key_q;

endmodule

`default_nettype wire

// File: rtl/key_event_decoder.sv
// ============================================================================
// Module   : key_event_decoder
// Purpose  : Turns a debounced button level into press/release/click/long strobes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_held
);

    localparam int unsigned CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic rise;
    logic fall;

    edge_detect u_edge_detect (
        .clk    (clk),
        .key_in (key_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             press_pulse_d,   press_pulse_q;
    logic             release_pulse_d, release_pulse_q;
    logic             single_click_d,  single_click_q;
    logic             double_click_d,  double_click_q;
    logic             long_press_d,    long_press_q;
    logic             long_held_d,     long_held_q;

    // Edges are tested before the counter threshold so a coincident key
    // change always wins over long-press or gap expiry.
    always_comb begin
        state_d         = state_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        single_click_d  = 1'b0;
        double_click_d  = 1'b0;
        long_press_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d       = DOWN1;
                    press_pulse_d = 1'b1;
                end
            end
            DOWN1: begin
                if (fall) begin
                    state_d         = GAP;
                    release_pulse_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d      = LONG;
                    long_press_d = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d       = DOWN2;
                    press_pulse_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d        = IDLE;
                    single_click_d = 1'b1;
                end
            end
            DOWN2: begin
                if (fall) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    double_click_d  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d        = LONG;
                    single_click_d = 1'b1;
                    long_press_d   = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        long_held_d = (state_d == LONG);

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            single_click_q  <= 1'b0;
            double_click_q  <= 1'b0;
            long_press_q    <= 1'b0;
            long_held_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            single_click_q  <= single_click_d;
            double_click_q  <= double_click_d;
            long_press_q    <= long_press_d;
            long_held_q     <= long_held_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign single_click  = single_click_q;
    assign double_click  = double_click_q;
    assign long_press    = long_press_q;
    assign long_held     = long_held_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_decoder.sv
// ============================================================================
// Module   : tb_key_event_decoder
// Purpose  : Scoreboard bench for key_event_decoder with LONG=8, GAP=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_key_event_decoder;

    localparam int L = 8;
    localparam int G = 4;

    // Output vector bit positions.
    localparam logic [5:0] M_PRESS  = 6'b100000;
    localparam logic [5:0] M_REL    = 6'b010000;
    localparam logic [5:0] M_SINGLE = 6'b001000;
    localparam logic [5:0] M_DOUBLE = 6'b000100;
    localparam logic [5:0] M_LPRESS = 6'b000010;
    localparam logic [5:0] M_HELD   = 6'b000001;

    logic clk = 1'b0;
    logic rst_n;
    logic key_in;
    logic press_pulse, release_pulse, single_click, double_click, long_press, long_held;

    key_event_decoder #(
        .LONG_CYCLES (L),
        .GAP_CYCLES  (G)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .single_click  (single_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .long_held     (long_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        cyc     = 0;
    int        scen    = 0;
    int        n_checks = 0;
    int        n_fail   = 0;
    logic      mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (press,rel,single,double,lpress,held)",
                     tag, obs, exp_v);
        end
    endtask

    task automatic push(input int c, input logic [5:0] m);
        sb_entry_t e;
        e.cyc  = c;
        e.mask = m;
        sb_q.push_back(e);
    endtask

    task automatic push_held(input int from_c, input int to_c);
        for (int c = from_c; c <= to_c; c++) push(c, M_HELD);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every cycle the observed outputs must equal the OR of all expectations
    // scheduled for that cycle (all zero when nothing is scheduled).
    always @(negedge clk) begin
        if (mon_en) begin
            logic [5:0] exp_v;
            exp_v = '0;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    exp_v |= sb_q[i].mask;
                    sb_q.delete(i);
                end
            end
            check($sformatf("s%0d_c%0d", scen, cyc),
                  {press_pulse, release_pulse, single_click, double_click, long_press, long_held},
                  exp_v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n  = 1'b0;
        key_in = 1'b0;

        // Reset with key low, then with key high held through deassertion.
        scen = 0;
        tick(2);
        mon_en = 1'b1;
        tick(3);
        key_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        key_in = 1'b0;               // fall in IDLE is ignored
        tick(4);

        // Single click.
        scen = 1;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        tick(3);
        c = cyc; key_in = 1'b0;
        push(c + 1, M_REL);
        push(c + 1 + G, M_SINGLE);
        tick(10);

        // Double click.
        scen = 2;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 3, M_REL);
        push(c + 5, M_PRESS);
        push(c + 7, M_REL | M_DOUBLE);
        tick(2); key_in = 1'b0;
        tick(2); key_in = 1'b1;
        tick(2); key_in = 1'b0;
        tick(10);

        // Long press, held 20 cycles.
        scen = 3;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 1 + L, M_LPRESS | M_HELD);
        push_held(c + 2 + L, c + 20);
        push(c + 21, M_REL);
        tick(20); key_in = 1'b0;
        tick(8);

        // Fall sampled on the long-threshold edge: short press.
        scen = 4;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 1 + L, M_REL);
        push(c + 1 + L + G, M_SINGLE);
        tick(L); key_in = 1'b0;
        tick(10);

        // Rise sampled on the gap-expiry edge: becomes a double click.
        scen = 5;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 3, M_REL);
        push(c + 3 + G, M_PRESS);
        push(c + 5 + G, M_REL | M_DOUBLE);
        tick(2); key_in = 1'b0;
        tick(G); key_in = 1'b1;
        tick(2); key_in = 1'b0;
        tick(10);

        // Second press held long: single click plus long press together.
        scen = 6;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 3, M_REL);
        push(c + 4, M_PRESS);
        push(c + 4 + L, M_SINGLE | M_LPRESS | M_HELD);
        push_held(c + 5 + L, c + 15);
        push(c + 16, M_REL);
        tick(2); key_in = 1'b0;
        tick(1); key_in = 1'b1;
        tick(12); key_in = 1'b0;
        tick(8);

        // Reset pulsed during LONG with the key held.
        scen = 7;
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 1 + L, M_LPRESS | M_HELD);
        push_held(c + 2 + L, c + 12);
        tick(12); rst_n = 1'b0;
        tick(2);  rst_n = 1'b1;
        tick(5);  key_in = 1'b0;
        tick(3);
        c = cyc; key_in = 1'b1;
        push(c + 1, M_PRESS);
        push(c + 3, M_REL);
        push(c + 3 + G, M_SINGLE);
        tick(2); key_in = 1'b0;
        tick(10);

        mon_en = 1'b0;
        check("sb_drained", 6'(sb_q.size()), 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
